// File: rtl/axis_arb_pkg.sv
// ============================================================================
// Module      : axis_arb_pkg
// Description : Shared types and helpers for the AXI-stream packet arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_arb_pkg;

  localparam int MAX_INPUTS = 16;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PASS = 1'b1
  } arb_state_t;

  // Width of a source index for n inputs.
  function automatic int src_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Index of the first set request at or after ptr, wrapping at n.
  function automatic logic [3:0] rr_pick(input logic [MAX_INPUTS-1:0] req,
                                         input logic [3:0]            ptr,
                                         input int                    n);
    logic [3:0] pick;
    logic       found;
    int         idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_INPUTS; k++) begin
      idx = (int'(ptr) + k) % n;
      if (!found && (k < n) && req[idx[3:0]]) begin
        pick  = idx[3:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_rr_grant.sv
// ============================================================================
// Module      : axis_rr_grant
// Description : Combinational round-robin picker (request vector + pointer).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_rr_grant
  import axis_arb_pkg::*;
#(
  parameter  int NUM_INPUTS = 4,
  localparam int SRC_W      = src_w(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [SRC_W-1:0]      ptr,
  output logic [SRC_W-1:0]      idx,
  output logic                  any
);

  logic [3:0] pick;

  assign pick = rr_pick(MAX_INPUTS'(req), 4'(ptr), NUM_INPUTS);
  assign idx  = SRC_W'(pick);
  assign any  = |req;

endmodule

`default_nettype wire

// File: rtl/axis_packet_arbiter.sv
// ============================================================================
// Module      : axis_packet_arbiter
// Description : Packet-granular round-robin arbiter onto one registered
//               AXI-stream output. Optional beat limit: AXIS_ARB_BEAT_LIMIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int NUM_INPUTS     = 4,
  parameter  int AXI_DATA_WIDTH = 32,
  parameter  int MAX_PKT_BEATS  = 256,
  localparam int SRC_W          = src_w(NUM_INPUTS)
) (
  input  logic                               Clk,
  input  logic                               Rst,
  input  logic [NUM_INPUTS-1:0]              S_axis_valid,
  output logic [NUM_INPUTS-1:0]              S_axis_ready,
  input  logic [NUM_INPUTS*AXI_DATA_WIDTH-1:0] S_axis_data,
  input  logic [NUM_INPUTS-1:0]              S_axis_last,
  input  logic                               M_axis_ready,
  output logic                               M_axis_valid,
  output logic [AXI_DATA_WIDTH-1:0]          M_axis_data,
  output logic                               M_axis_last,
  output logic [SRC_W-1:0]                   M_axis_src,
  output logic                               Trunc_pulse
);

  if (NUM_INPUTS < 2 || NUM_INPUTS > MAX_INPUTS || MAX_PKT_BEATS < 1) begin : g_param_check
    $error("axis_packet_arbiter: parameter out of range");
  end

  arb_state_t                state, state_nxt;
  logic [SRC_W-1:0]          grant, rr_ptr, pick, next_ptr;
  logic                      pick_any;
  logic [AXI_DATA_WIDTH-1:0] sel_data;
  logic                      sel_valid, sel_last, out_last, s_hs, pkt_end;

  axis_rr_grant #(.NUM_INPUTS(NUM_INPUTS)) u_rr (
    .req (S_axis_valid),
    .ptr (rr_ptr),
    .idx (pick),
    .any (pick_any)
  );

  assign sel_data  = S_axis_data[int'(grant)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  assign sel_valid = S_axis_valid[grant];
  assign sel_last  = S_axis_last[grant];
  assign pkt_end   = s_hs && out_last;
  assign next_ptr  = (int'(grant) == NUM_INPUTS - 1) ? '0 : grant + SRC_W'(1);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pick_any) state_nxt = S_PASS;
      S_PASS:  if (pkt_end)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Ready depends only on the registered output stage, so a full stage
  // accepts a new beat in the same cycle the downstream drains it.
  always_comb begin
    S_axis_ready = '0;
    s_hs         = 1'b0;
    if (state == S_PASS && (!M_axis_valid || M_axis_ready)) begin
      S_axis_ready[grant] = 1'b1;
      s_hs                = sel_valid;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      grant        <= '0;
      rr_ptr       <= '0;
      M_axis_valid <= 1'b0;
      M_axis_data  <= '0;
      M_axis_last  <= 1'b0;
      M_axis_src   <= '0;
    end else begin
      if (state == S_IDLE && pick_any) grant <= pick;
      if (pkt_end) rr_ptr <= next_ptr;
      if (s_hs) begin
        M_axis_valid <= 1'b1;
        M_axis_data  <= sel_data;
        M_axis_last  <= out_last;
        M_axis_src   <= grant;
      end else if (M_axis_ready) begin
        M_axis_valid <= 1'b0;
      end
    end
  end

`ifdef AXIS_ARB_BEAT_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_PKT_BEATS + 1);

  logic [CNT_W-1:0] beat_cnt;
  logic             limit_hit, trunc_q;

  assign limit_hit   = (beat_cnt == CNT_W'(MAX_PKT_BEATS - 1));
  assign out_last    = sel_last || limit_hit;
  assign Trunc_pulse = trunc_q;

  // Pulse only when the limit actually cut a packet short.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      beat_cnt <= '0;
      trunc_q  <= 1'b0;
    end else begin
      trunc_q <= s_hs && limit_hit && !sel_last;
      if (pkt_end)   beat_cnt <= '0;
      else if (s_hs) beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end
`else
  assign out_last    = sel_last;
  assign Trunc_pulse = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_packet_arbiter.sv
// ============================================================================
// Module      : tb_axis_packet_arbiter
// Description : Self-checking bench: directed sequences, round-robin order
//               table and randomized traffic against a per-source scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_packet_arbiter;

  localparam int NI = 4;
  localparam int W  = 32;
  localparam int SW = 2;
`ifdef AXIS_ARB_BEAT_LIMIT_EN
  localparam int MAXB = 4;
`else
  localparam int MAXB = 256;
`endif

  logic            Clk = 1'b0;
  logic            Rst = 1'b1;
  logic [NI-1:0]   s_valid, s_ready, s_last;
  logic [NI*W-1:0] s_data;
  logic            m_ready, m_valid, m_last, trunc;
  logic [W-1:0]    m_data;
  logic [SW-1:0]   m_src;

  axis_packet_arbiter #(
    .NUM_INPUTS     (NI),
    .AXI_DATA_WIDTH (W),
    .MAX_PKT_BEATS  (MAXB)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .S_axis_valid (s_valid),
    .S_axis_ready (s_ready),
    .S_axis_data  (s_data),
    .S_axis_last  (s_last),
    .M_axis_ready (m_ready),
    .M_axis_valid (m_valid),
    .M_axis_data  (m_data),
    .M_axis_last  (m_last),
    .M_axis_src   (m_src),
    .Trunc_pulse  (trunc)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  typedef struct {
    int           src;
    logic [W-1:0] data;
    logic         last;
    int           cyc;
  } obs_t;

  typedef struct {
    logic [NI-1:0] mask;
    int            prior;
    int            count;
    logic [15:0]   order;
  } vec_t;

  beat_t src_q[NI][$];
  beat_t exp_q[NI][$];
  obs_t  log_q[$];

  int          tests = 0, fails = 0;
  int          cyc = 0, seq = 0, trunc_cnt = 0;
  int          valid_pct = 100, ready_pct = 100;
  logic [NI-1:0] held = '0;
  logic        open = 1'b0;
  int          open_src = 0;
  int          seg[NI];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_pkt(input int src, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = {8'(src), 24'(seq)};
      b.last = (k == len - 1);
      seq++;
      src_q[src].push_back(b);
      exp_q[src].push_back(b);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NI; i++) n += src_q[i].size() + exp_q[i].size();
    return n;
  endfunction

  // Reference: each source's beats leave in order; packets never interleave;
  // a packet reaching MAXB beats (limit build) is cut at that beat.
  task automatic score(input int src, input logic [W-1:0] data, input logic last);
    beat_t e;
    logic  exp_last;
    obs_t  o;
    if (exp_q[src].size() == 0) begin
      check("sb_extra_beat", 64'(src + 1), 64'(0));
      return;
    end
    e = exp_q[src].pop_front();
    exp_last = e.last;
`ifdef AXIS_ARB_BEAT_LIMIT_EN
    if (seg[src] + 1 == MAXB) exp_last = 1'b1;
`endif
    seg[src] = exp_last ? 0 : seg[src] + 1;
    check("sb_data", 64'(data), 64'(e.data));
    check("sb_last", 64'(last), 64'(exp_last));
    if (open) check("no_interleave", 64'(src), 64'(open_src));
    open     = !last;
    open_src = src;
    o.src = src; o.data = data; o.last = last; o.cyc = cyc;
    log_q.push_back(o);
  endtask

  task automatic cycle();
    logic [NI-1:0] hs;
    logic          ohs;
    logic [W-1:0]  od;
    logic          ol;
    int            os;
    @(negedge Clk);
    if (trunc) trunc_cnt++;
    for (int i = 0; i < NI; i++) begin
      if (src_q[i].size() == 0) begin
        s_valid[i] = 1'b0;
      end else if (held[i] || ($urandom_range(99) < 32'(valid_pct))) begin
        s_valid[i]        = 1'b1;
        s_data[i*W +: W]  = src_q[i][0].data;
        s_last[i]         = src_q[i][0].last;
      end else begin
        s_valid[i] = 1'b0;
      end
    end
    m_ready = ($urandom_range(99) < 32'(ready_pct));
    #1;
    hs   = s_valid & s_ready;
    held = s_valid & ~s_ready;
    ohs  = m_valid && m_ready;
    od   = m_data;
    ol   = m_last;
    os   = int'(m_src);
    @(posedge Clk);
    cyc++;
    for (int i = 0; i < NI; i++)
      if (hs[i]) void'(src_q[i].pop_front());
    if (ohs) score(os, od, ol);
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (pending() > 0 && n < budget) begin
      cycle();
      n++;
    end
    check(name, 64'(pending()), 64'(0));
    for (int i = 0; i < NI; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    repeat (3) cycle();
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #2;
    Rst = 1'b1;
    #1;
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_s_ready", 64'(s_ready), 64'(0));
    s_valid = '0;
    s_last  = '0;
    held    = '0;
    open    = 1'b0;
    for (int i = 0; i < NI; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
      seg[i] = 0;
    end
    @(posedge Clk);
    @(negedge Clk);
    check("rst_m_valid_held", 64'(m_valid), 64'(0));
    check("rst_m_last", 64'(m_last), 64'(0));
    check("rst_m_data", 64'(m_data), 64'(0));
    check("rst_m_src", 64'(m_src), 64'(0));
    check("rst_trunc", 64'(trunc), 64'(0));
    Rst = 1'b0;
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vt[6];
    logic [15:0]  got;
    logic [W-1:0] d2;
    int           c0;

    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    m_ready = 1'b0;
    for (int i = 0; i < NI; i++) seg[i] = 0;

    vt[0] = '{4'b0111, 2, 3, 16'h0210};
    vt[1] = '{4'b0111, 1, 3, 16'h0102};
    vt[2] = '{4'b1010, 2, 2, 16'h0013};
    vt[3] = '{4'b1111, 3, 4, 16'h3210};
    vt[4] = '{4'b1001, 0, 2, 16'h0003};
    vt[5] = '{4'b0110, 3, 2, 16'h0021};

    do_reset();

    // Single source: registered grant, then one beat per cycle.
    log_q.delete();
    c0 = cyc;
    push_pkt(0, 3);
    drain(50, "t1_drain");
    check("t1_beats", 64'(log_q.size()), 64'(3));
    for (int k = 0; k < 3 && k < log_q.size(); k++) begin
      check("t1_src", 64'(log_q[k].src), 64'(0));
      check("t1_cycle", 64'(log_q[k].cyc), 64'(c0 + 3 + k));
      check("t1_last", 64'(log_q[k].last), 64'(k == 2));
    end

    // Round-robin order table: a prior packet sets the pointer.
    for (int v = 0; v < 6; v++) begin
      push_pkt(vt[v].prior, 1);
      drain(50, "rr_prior_drain");
      log_q.delete();
      for (int i = 0; i < NI; i++)
        if (vt[v].mask[i]) push_pkt(i, 3);
      drain(200, "rr_drain");
      got = '0;
      for (int k = 0; k < vt[v].count; k++)
        if (3 * k < log_q.size()) got[4*k +: 4] = 4'(log_q[3*k].src);
      check("rr_order", 64'(got), 64'(vt[v].order));
      check("rr_beats", 64'(log_q.size()), 64'(3 * vt[v].count));
    end

    // Downstream stall mid-packet.
    log_q.delete();
    push_pkt(2, 6);
    d2 = exp_q[2][2].data;
    for (int n = 0; n < 50 && log_q.size() < 2; n++) cycle();
    ready_pct = 0;
    for (int n = 0; n < 5; n++) begin
      cycle();
      #1;
      check("stall_valid", 64'(m_valid), 64'(1));
      check("stall_data", 64'(m_data), 64'(d2));
      check("stall_s_ready", 64'(s_ready[2]), 64'(0));
    end
    ready_pct = 100;
    drain(100, "stall_drain");
    check("stall_beats", 64'(log_q.size()), 64'(6));

    // Reset mid-packet on input 3, after a packet that moved the pointer off 0.
    push_pkt(0, 1);
    drain(50, "t5_prior_drain");
    log_q.delete();
    push_pkt(3, 6);
    for (int n = 0; n < 50 && log_q.size() < 2; n++) cycle();
    do_reset();
    log_q.delete();
    push_pkt(3, 3);
    push_pkt(0, 3);
    drain(100, "t5_drain");
    check("t5_beats", 64'(log_q.size()), 64'(6));
    if (log_q.size() == 6) begin
      check("t5_first_src", 64'(log_q[0].src), 64'(0));
      check("t5_second_src", 64'(log_q[3].src), 64'(3));
    end

`ifdef AXIS_ARB_BEAT_LIMIT_EN
    begin
      int          t0;
      logic [5:0]  lasts;
      t0 = trunc_cnt;
      log_q.delete();
      push_pkt(1, 6);
      drain(100, "t6_drain");
      check("t6_beats", 64'(log_q.size()), 64'(6));
      lasts = '0;
      for (int k = 0; k < 6 && k < log_q.size(); k++) lasts[k] = log_q[k].last;
      check("t6_last_pattern", 64'(lasts), 64'(6'b101000));
      check("t6_trunc_pulses", 64'(trunc_cnt - t0), 64'(1));
    end
`endif

    // Randomized traffic.
    valid_pct = 70;
    ready_pct = 80;
    for (int p = 0; p < 200; p++)
      for (int i = 0; i < NI; i++) push_pkt(i, int'($urandom_range(1, 8)));
    drain(60000, "rand_drain");
    valid_pct = 100;
    ready_pct = 100;

`ifndef AXIS_ARB_BEAT_LIMIT_EN
    check("trunc_never", 64'(trunc_cnt), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
